// File: rtl/anc_pkg.sv
// Shared types and default sizing for the ANC sample feeder.
package anc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } anc_state_t;

    localparam int DEF_DEPTH = 8;
    localparam int DEF_GAP   = 3;

endpackage

// File: rtl/anc_sync_fifo.sv
// Pair buffer for the feeder: storage, wrapping pointers and occupancy count.
module anc_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic [4:0]   level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [4:0]    count_r;
    logic          push_s;
    logic          pop_s;

    // flush wins over any transfer in the same cycle
    assign push_s  = push && !flush;
    assign pop_s   = pop && !flush;
    assign rd_data = mem_r[rd_ptr_r];
    assign level   = count_r;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= 5'd0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= 5'd0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 5'd1;
                2'b01:   count_r <= count_r - 5'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage write; contents are not cleared by reset
    always_ff @(posedge clk) begin
        if (push_s && rst_n) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

endmodule

// File: rtl/anc_sample_feeder.sv
// Buffers upstream {x,y} sample pairs and issues them to the adaptive filter
// as single-cycle pulses separated by at least GAP idle cycles.
module anc_sample_feeder
    import anc_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int GAP   = DEF_GAP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_x,
    input  logic [7:0]  s_y,
    input  logic        s_vld,
    output logic        s_rdy,
    input  logic        flush,
    output logic [7:0]  xin,
    output logic [7:0]  yin,
    output logic        vld,
    input  logic        rdy,
    output logic [4:0]  level,
    output logic [15:0] issued_cnt
);

    localparam logic [4:0] DEPTH_L  = 5'(DEPTH);
    localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);

    anc_state_t  state_r, state_nxt_s;
    logic [3:0]  gap_cnt_r, gap_cnt_nxt_s;
    logic        issue_s;
    logic        can_issue_s;
    logic        push_s;
    logic [15:0] head_s;
    logic [7:0]  xin_r, yin_r;
    logic        vld_r;
    logic [15:0] issued_cnt_r;

    assign s_rdy      = (level < DEPTH_L) && !flush;
    assign push_s     = s_vld && s_rdy;
    assign xin        = xin_r;
    assign yin        = yin_r;
    assign vld        = vld_r;
    assign issued_cnt = issued_cnt_r;

    anc_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (16)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .push    (push_s),
        .wr_data ({s_x, s_y}),
        .pop     (issue_s),
        .rd_data (head_s),
        .level   (level)
    );

    // Next-state, gap counter and issue decision
    always_comb begin
        state_nxt_s   = state_r;
        gap_cnt_nxt_s = gap_cnt_r;
        issue_s       = 1'b0;
        can_issue_s   = (level != 5'd0) && rdy && !flush;
        if (flush) begin
            state_nxt_s   = ST_IDLE;
            gap_cnt_nxt_s = 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (can_issue_s) begin
                        state_nxt_s = ST_SEND;
                        issue_s     = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SEND: begin
                    state_nxt_s   = ST_WAIT;
                    gap_cnt_nxt_s = GAP_LOAD;
                end
                ST_WAIT: begin
                    if (gap_cnt_r != 4'd0) begin
                        gap_cnt_nxt_s = gap_cnt_r - 4'd1;
                    end else if (can_issue_s) begin
                        state_nxt_s = ST_SEND;
                        issue_s     = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt_s   = ST_IDLE;
                    gap_cnt_nxt_s = 4'd0;
                end
            endcase
        end
    end

    // State, counter and registered filter-side outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            gap_cnt_r    <= 4'd0;
            vld_r        <= 1'b0;
            xin_r        <= 8'd0;
            yin_r        <= 8'd0;
            issued_cnt_r <= 16'd0;
        end else begin
            state_r   <= state_nxt_s;
            gap_cnt_r <= gap_cnt_nxt_s;
            vld_r     <= issue_s;
            if (issue_s) begin
                xin_r        <= head_s[15:8];
                yin_r        <= head_s[7:0];
                issued_cnt_r <= issued_cnt_r + 16'd1;
            end else begin
                xin_r        <= xin_r;
                yin_r        <= yin_r;
                issued_cnt_r <= issued_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_anc_sample_feeder.sv
// Randomised and directed bench for anc_sample_feeder against a queue-based timing model.
module tb_anc_sample_feeder;

    localparam int DEPTH = 8;
    localparam int GAP   = 3;

    logic        clk = 1'b0;
    logic        rst_n, flush, s_vld, rdy;
    logic [7:0]  s_x, s_y;
    logic        s_rdy, vld;
    logic [7:0]  xin, yin;
    logic [4:0]  level;
    logic [15:0] issued_cnt;

    always #5 clk = ~clk;

    anc_sample_feeder #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .s_x(s_x), .s_y(s_y), .s_vld(s_vld),
        .s_rdy(s_rdy), .flush(flush), .xin(xin), .yin(yin), .vld(vld),
        .rdy(rdy), .level(level), .issued_cnt(issued_cnt)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // reference model: buffered pairs, last issued values, issue timing
    logic [15:0] q[$];
    logic [7:0]  m_x = 8'd0, m_y = 8'd0;
    logic [15:0] m_cnt = 16'd0;
    int          edge_k = 0;
    int          last_issue = -1000;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_k);
        end
    endtask

    // one clock cycle: drive, check s_rdy, advance model, check outputs
    task automatic step(input logic r, input logic f, input logic v, input logic rd,
                        input logic [7:0] x, input logic [7:0] y, output logic acc);
        logic exp_rdy, issue;
        logic [15:0] hd;
        rst_n = r; flush = f; s_vld = v; rdy = rd; s_x = x; s_y = y;
        #1;
        exp_rdy = (q.size() < DEPTH) && !f;
        check_val("s_rdy", {31'd0, s_rdy}, {31'd0, exp_rdy});
        issue = r && !f && (q.size() > 0) && rd && (edge_k - last_issue >= GAP + 1);
        acc   = r && v && exp_rdy;
        @(posedge clk);
        if (!r) begin
            q.delete(); m_x = 8'd0; m_y = 8'd0; m_cnt = 16'd0; last_issue = -1000;
        end else if (f) begin
            q.delete(); last_issue = -1000;
        end else begin
            if (issue) begin
                hd = q.pop_front();
                m_x = hd[15:8]; m_y = hd[7:0]; m_cnt = m_cnt + 16'd1; last_issue = edge_k;
            end
            if (acc) q.push_back({x, y});
        end
        edge_k++;
        #1;
        check_val("vld", {31'd0, vld}, {31'd0, issue});
        check_val("xin", {24'd0, xin}, {24'd0, m_x});
        check_val("yin", {24'd0, yin}, {24'd0, m_y});
        check_val("level", {27'd0, level}, q.size());
        check_val("issued_cnt", {16'd0, issued_cnt}, {16'd0, m_cnt});
        @(negedge clk);
    endtask

    logic acc;
    int   got, cyc, pulses;

    initial begin
        rst_n = 1'b0; flush = 1'b0; s_vld = 1'b0; rdy = 1'b0; s_x = 8'd0; s_y = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset state
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, acc);
        check_val("rst_vld", {31'd0, vld}, 32'd0);
        check_val("rst_level", {27'd0, level}, 32'd0);
        check_val("rst_s_rdy_after", {31'd0, s_rdy}, 32'd1);

        // single pair, issue one cycle after acceptance
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 8'h20, acc);
        check_val("single_vld_early", {31'd0, vld}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, acc);
        check_val("single_xin", {24'd0, xin}, 32'h10);
        check_val("single_yin", {24'd0, yin}, 32'h20);
        check_val("single_cnt", {16'd0, issued_cnt}, 32'd1);
        repeat (6) step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, acc);

        // fill to full with rdy low, then drain with fixed spacing
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b0, 1'b1, 1'b0, 8'(8'hA0 + i), 8'(8'h50 + i), acc);
        check_val("full_level", {27'd0, level}, DEPTH);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'hEE, 8'hEE, acc);
        check_val("full_reject", {31'd0, acc}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 4 * DEPTH + 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, acc);
            if (vld) pulses++;
        end
        check_val("drain_pulses", pulses, DEPTH);
        check_val("drain_level", {27'd0, level}, 32'd0);

        // continuous offer of 20 pairs, forcing backpressure and pointer wrap
        got = 0; cyc = 0;
        while (got < 20 && cyc < 400) begin
            step(1'b1, 1'b0, 1'b1, 1'b1, 8'(got), 8'(8'hFF - got), acc);
            if (acc) got++;
            cyc++;
        end
        check_val("stream_accepted", got, 20);
        repeat (4 * DEPTH + 8) step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, acc);

        // flush during WAIT with pairs still buffered
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h30 + i), 8'(8'h40 + i), acc);
        cyc = 0;
        do begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, acc);
            cyc++;
        end while (!vld && cyc < 20);
        check_val("flush_pre_vld", {31'd0, vld}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, acc);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h77, 8'h77, acc);
        check_val("flush_level", {27'd0, level}, 32'd0);
        repeat (12) step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, acc);

        // issued_cnt wrap
        force dut.issued_cnt_r = 16'hFFFF;
        #1;
        release dut.issued_cnt_r;
        m_cnt = 16'hFFFF;
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 8'hA5, acc);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, acc);
        check_val("wrap_cnt", {16'd0, issued_cnt}, 32'd0);
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, acc);

        // reset while a pulse is out and pairs are buffered
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 1'b1, 1'b0, 8'(8'hC0 + i), 8'(8'hD0 + i), acc);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, acc);
        check_val("prerst_vld", {31'd0, vld}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, acc);
        check_val("rst_mid_xin", {24'd0, xin}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, acc);

        // random traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0),
                 8'($urandom), 8'($urandom), acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
